// File: rtl/axi_pkg.sv
// axi_pkg: AXI constants and the line bridge state encoding, shared by AXI users.
package axi_pkg;
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
endpackage

// File: rtl/axi_line_bridge.sv
// axi_line_bridge: turns one line or single-word request into an AXI3 burst.
// One transaction in flight; the line register doubles as write source and read sink.
module axi_line_bridge
    import axi_pkg::*;
#(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_uncached,
    input  logic [31:0]             req_addr,
    input  logic [3:0]              req_wstrb,
    input  logic [32*LINE_WORDS-1:0] req_wline,
    output logic                    resp_valid,
    output logic [32*LINE_WORDS-1:0] resp_rline,
    output logic                    resp_err,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int CW = $clog2(LINE_WORDS) + 1;
    state_t            state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     beats;
    logic [32*LINE_WORDS-1:0] line;
    logic [31:0]       addr_q;
    logic              unc_q;
    logic [3:0]        strb_q;
    logic              last_beat;
    logic              unused;
    assign beats      = unc_q ? CW'(1) : CW'(LINE_WORDS);
    assign last_beat  = count == beats - CW'(1);
    assign unused     = ^{rid, bid};
    assign resp_rline = line;
    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = arlen;
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wdata   = line[32*count +: 32];
    assign wstrb   = unc_q ? strb_q : 4'hF;
    assign wlast   = wvalid && last_beat;
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            count      <= '0;
            line       <= '0;
            addr_q     <= '0;
            unc_q      <= 1'b0;
            strb_q     <= 4'd0;
            req_ready  <= 1'b1;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_uncached ? {req_addr[31:2], 2'b00}
                                              : req_addr & ~32'(4*LINE_WORDS - 1);
                    unc_q     <= req_uncached;
                    strb_q    <= req_wstrb;
                    line      <= req_wline;
                    resp_err  <= 1'b0;
                    count     <= '0;
                    req_ready <= 1'b0;
                    arvalid   <= !req_write;
                    awvalid   <= req_write;
                    state     <= req_write ? AW : AR;
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= R;
                end
                R: if (rvalid) begin
                    // beats beyond the burst length are accepted but dropped
                    if (count != beats) begin
                        line[32*count +: 32] <= rdata;
                        count                <= count + 1'b1;
                    end
                    resp_err <= resp_err | (rresp != RESP_OKAY);
                    if (rlast) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                AW: if (awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    state   <= W;
                end
                W: if (wready) begin
                    count <= count + 1'b1;
                    if (last_beat) begin
                        wvalid <= 1'b0;
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: if (bvalid) begin
                    resp_err   <= resp_err | (bresp != RESP_OKAY);
                    bready     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_line_bridge.sv
// tb_axi_line_bridge: directed vectors for the line bridge, 8-word and 4-word instances.
module tb_axi_line_bridge;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;
    logic         use4, req_valid, req_write, req_uncached;
    logic [31:0]  req_addr;
    logic [3:0]   req_wstrb;
    logic [255:0] wl;
    logic         req_valid_8, req_valid_4;
    logic         arready, rvalid, rlast, awready, wready, bvalid;
    logic [31:0]  rdata;
    logic [1:0]   rresp, bresp;
    logic [3:0]   rid, bid;
    logic         req_ready_8, resp_valid_8, resp_err_8, arvalid_8, rready_8, awvalid_8, wvalid_8, wlast_8, bready_8;
    logic [255:0] resp_rline_8;
    logic [3:0]   arid_8, arcache_8, awid_8, awcache_8, wid_8, wstrb_8;
    logic [31:0]  araddr_8, awaddr_8, wdata_8;
    logic [7:0]   arlen_8, awlen_8;
    logic [2:0]   arsize_8, arprot_8, awsize_8, awprot_8;
    logic [1:0]   arburst_8, arlock_8, awburst_8, awlock_8;
    logic         req_ready_4, resp_valid_4, resp_err_4, arvalid_4, rready_4, awvalid_4, wvalid_4, wlast_4, bready_4;
    logic [127:0] resp_rline_4;
    logic [3:0]   arid_4, arcache_4, awid_4, awcache_4, wid_4, wstrb_4;
    logic [31:0]  araddr_4, awaddr_4, wdata_4;
    logic [7:0]   arlen_4, awlen_4;
    logic [2:0]   arsize_4, arprot_4, awsize_4, awprot_4;
    logic [1:0]   arburst_4, arlock_4, awburst_4, awlock_4;
    int checks = 0;
    int failures = 0;
    assign req_valid_8 = req_valid && !use4;
    assign req_valid_4 = req_valid && use4;
    logic        m_req_ready, m_resp_valid, m_resp_err, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [3:0]  m_awid, m_wstrb, m_wid;
    assign m_req_ready  = use4 ? req_ready_4  : req_ready_8;
    assign m_resp_valid = use4 ? resp_valid_4 : resp_valid_8;
    assign m_resp_err   = use4 ? resp_err_4   : resp_err_8;
    assign m_awvalid    = use4 ? awvalid_4    : awvalid_8;
    assign m_awaddr     = use4 ? awaddr_4     : awaddr_8;
    assign m_awlen      = use4 ? awlen_4      : awlen_8;
    assign m_awsize     = use4 ? awsize_4     : awsize_8;
    assign m_awburst    = use4 ? awburst_4    : awburst_8;
    assign m_awid       = use4 ? awid_4       : awid_8;
    assign m_wvalid     = use4 ? wvalid_4     : wvalid_8;
    assign m_wdata      = use4 ? wdata_4      : wdata_8;
    assign m_wstrb      = use4 ? wstrb_4      : wstrb_8;
    assign m_wlast      = use4 ? wlast_4      : wlast_8;
    assign m_wid        = use4 ? wid_4        : wid_8;
    assign m_bready     = use4 ? bready_4     : bready_8;
    axi_line_bridge #(.LINE_WORDS(8), .AXI_ID(4'd0)) u8 (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid_8), .req_ready(req_ready_8),
        .req_write(req_write), .req_uncached(req_uncached), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wline(wl), .resp_valid(resp_valid_8), .resp_rline(resp_rline_8), .resp_err(resp_err_8),
        .arid(arid_8), .araddr(araddr_8), .arlen(arlen_8), .arsize(arsize_8), .arburst(arburst_8),
        .arlock(arlock_8), .arcache(arcache_8), .arprot(arprot_8), .arvalid(arvalid_8), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready_8),
        .awid(awid_8), .awaddr(awaddr_8), .awlen(awlen_8), .awsize(awsize_8), .awburst(awburst_8),
        .awlock(awlock_8), .awcache(awcache_8), .awprot(awprot_8), .awvalid(awvalid_8), .awready(awready),
        .wid(wid_8), .wdata(wdata_8), .wstrb(wstrb_8), .wlast(wlast_8), .wvalid(wvalid_8), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready_8)
    );
    axi_line_bridge #(.LINE_WORDS(4), .AXI_ID(4'd0)) u4 (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_write(req_write), .req_uncached(req_uncached), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wline(wl[127:0]), .resp_valid(resp_valid_4), .resp_rline(resp_rline_4), .resp_err(resp_err_4),
        .arid(arid_4), .araddr(araddr_4), .arlen(arlen_4), .arsize(arsize_4), .arburst(arburst_4),
        .arlock(arlock_4), .arcache(arcache_4), .arprot(arprot_4), .arvalid(arvalid_4), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready_4),
        .awid(awid_4), .awaddr(awaddr_4), .awlen(awlen_4), .awsize(awsize_4), .awburst(awburst_4),
        .awlock(awlock_4), .awcache(awcache_4), .awprot(awprot_4), .awvalid(awvalid_4), .awready(awready),
        .wid(wid_4), .wdata(wdata_4), .wstrb(wstrb_4), .wlast(wlast_4), .wvalid(wvalid_4), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready_4)
    );
    typedef struct {
        logic        unc;
        logic        hold;
        logic [31:0] addr;
        int          rbeats;
        int          err_beat;
        logic [31:0] rbase;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        int          exp_lat;
        logic        exp_err;
    } rd_vec_t;
    rd_vec_t rv[7];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask
    task automatic do_read(input rd_vec_t v, input string tag);
        int nb, lim, beat;
        logic done;
        logic [31:0] exp;
        nb = v.unc ? 1 : 8;
        lim = v.rbeats < nb ? v.rbeats : nb;
        beat = 0;
        done = 1'b0;
        use4 = 1'b0;
        chk({tag, "_idle_ready"}, 32'(req_ready_8), 1);
        req_valid = 1'b1; req_write = 1'b0; req_uncached = v.unc; req_addr = v.addr; req_wstrb = 4'h0;
        tick();
        if (!v.hold) req_valid = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (v.hold) req_addr = $urandom;
            if (resp_valid_8) begin
                req_valid = 1'b0;
                done = 1'b1;
                chk({tag, "_latency"}, c, v.exp_lat);
                chk({tag, "_err"}, 32'(resp_err_8), 32'(v.exp_err));
                chk({tag, "_done_ready"}, 32'(req_ready_8), 0);
                for (int i = 0; i < 8; i++) begin
                    exp = i < lim ? v.rbase + 32'(i) : wl[32*i +: 32];
                    chk($sformatf("%s_word%0d", tag, i), resp_rline_8[32*i +: 32], exp);
                end
            end else begin
                chk({tag, "_busy_ready"}, 32'(req_ready_8), 0);
                arready = 1'b1;
                rvalid = beat < v.rbeats;
                rdata = v.rbase + 32'(beat);
                rresp = beat == v.err_beat ? 2'b10 : 2'b00;
                rlast = beat == v.rbeats - 1;
                if (arvalid_8) begin
                    chk({tag, "_araddr"}, araddr_8, v.exp_araddr);
                    chk({tag, "_arlen"}, 32'(arlen_8), 32'(v.exp_arlen));
                    chk({tag, "_arfixed"}, {arid_8, arsize_8, arburst_8, arlock_8, arcache_8, arprot_8}, {4'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
                end
                if (rready_8 && rvalid) beat++;
                tick();
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 1);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tick();
        chk({tag, "_after_valid"}, 32'(resp_valid_8), 0);
        chk({tag, "_after_ready"}, 32'(req_ready_8), 1);
    endtask
    task automatic do_write(input logic s4, input logic unc, input logic [31:0] addr, input logic [3:0] strb,
                            input logic stall, input logic [1:0] br, input logic [31:0] exp_awaddr,
                            input int nb, input logic [7:0] exp_awlen, input string tag);
        int beats, bc;
        logic done;
        beats = 0; bc = -10; done = 1'b0;
        use4 = s4;
        chk({tag, "_idle_ready"}, 32'(m_req_ready), 1);
        req_valid = 1'b1; req_write = 1'b1; req_uncached = unc; req_addr = addr; req_wstrb = strb;
        tick();
        req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wstrb = 4'h0;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (m_resp_valid) begin
                done = 1'b1;
                chk({tag, "_resp_after_b"}, c, bc + 1);
                chk({tag, "_beats"}, beats, nb);
                chk({tag, "_err"}, 32'(m_resp_err), 32'(br != 2'b00));
            end else begin
                awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bvalid = beats == nb;
                bresp = br;
                if (m_awvalid && awready) begin
                    chk({tag, "_awaddr"}, m_awaddr, exp_awaddr);
                    chk({tag, "_awlen"}, 32'(m_awlen), 32'(exp_awlen));
                    chk({tag, "_awfixed"}, {m_awid, m_awsize, m_awburst}, {4'd0, 3'b010, 2'b01});
                end
                if (m_wvalid && wready) begin
                    chk($sformatf("%s_wdata%0d", tag, beats), m_wdata, wl[32*beats +: 32]);
                    chk($sformatf("%s_wlast%0d", tag, beats), 32'(m_wlast), 32'(beats == nb - 1));
                    chk($sformatf("%s_wstrb%0d", tag, beats), {m_wid, m_wstrb}, {4'd0, unc ? strb : 4'hF});
                    beats++;
                end
                if (m_bready && bvalid) bc = c;
                tick();
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        tick();
        chk({tag, "_after_valid"}, 32'(m_resp_valid), 0);
        chk({tag, "_after_ready"}, 32'(m_req_ready), 1);
    endtask
    initial begin
        int beat;
        logic hit;
        use4 = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_uncached = 1'b0; req_addr = '0; req_wstrb = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0; rid = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
        for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        rv[0] = '{1'b0, 1'b0, 32'h1000_0014, 8, -1, 32'h0,   32'h1000_0000, 8'd7, 10, 1'b0};
        rv[1] = '{1'b0, 1'b0, 32'h2000_0044, 8,  5, 32'h100, 32'h2000_0040, 8'd7, 10, 1'b1};
        rv[2] = '{1'b0, 1'b0, 32'h3000_001C, 8, -1, 32'h200, 32'h3000_0000, 8'd7, 10, 1'b0};
        rv[3] = '{1'b1, 1'b0, 32'h4000_0007, 1, -1, 32'h300, 32'h4000_0004, 8'd0, 3,  1'b0};
        rv[4] = '{1'b0, 1'b0, 32'h5000_0020, 3, -1, 32'h400, 32'h5000_0020, 8'd7, 5,  1'b0};
        rv[5] = '{1'b1, 1'b0, 32'h6000_0002, 2, -1, 32'h500, 32'h6000_0000, 8'd0, 4,  1'b0};
        rv[6] = '{1'b0, 1'b1, 32'h7000_00FC, 8, -1, 32'h600, 32'h7000_00E0, 8'd7, 10, 1'b0};
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_req_ready", {req_ready_8, req_ready_4}, 2'b11);
        chk("rst_resp", {resp_valid_8, resp_err_8, resp_valid_4, resp_err_4}, 4'b0);
        chk("rst_valids", {arvalid_8, rready_8, awvalid_8, wvalid_8, wlast_8, bready_8}, 6'b0);
        chk("rst_rline", 32'(|resp_rline_8), 0);
        aresetn = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) do_read(rv[k], $sformatf("rd%0d", k));
        use4 = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_uncached = 1'b0; req_addr = 32'h0800_0000;
        tick();
        req_valid = 1'b0;
        beat = 0; hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            arready = 1'b1; rvalid = 1'b1; rdata = 32'(beat); rlast = 1'b0; rresp = 2'b00;
            if (rready_8 && beat == 3) begin
                aresetn = 1'b0;
                hit = 1'b1;
            end else if (rready_8) beat++;
            tick();
        end
        chk("mid_rst_reached", 32'(hit), 1);
        chk("mid_rst_valids", {arvalid_8, rready_8, awvalid_8, wvalid_8, bready_8}, 5'b0);
        chk("mid_rst_ready", 32'(req_ready_8), 1);
        chk("mid_rst_resp", {resp_valid_8, resp_err_8}, 2'b0);
        chk("mid_rst_rline", 32'(|resp_rline_8), 0);
        aresetn = 1'b1; rvalid = 1'b0; arready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_rst_no_resp", 32'(resp_valid_8), 0);
        end
        do_read(rv[0], "rd_after_rst");
        do_write(1'b1, 1'b0, 32'h0000_1238, 4'h0,    1'b1, 2'b00, 32'h0000_1230, 4, 8'd3, "cwr4");
        do_write(1'b0, 1'b1, 32'h1FAF_F003, 4'b0010, 1'b0, 2'b00, 32'h1FAF_F000, 1, 8'd0, "uwr8");
        do_write(1'b1, 1'b0, 32'h0000_2004, 4'h0,    1'b1, 2'b10, 32'h0000_2000, 4, 8'd3, "cwr4err");
        do_write(1'b1, 1'b0, 32'h0000_3010, 4'h0,    1'b0, 2'b00, 32'h0000_3010, 4, 8'd3, "cwr4clean");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_line_bridge.md
AXI_LINE_BRIDGE -- requirements
Module: axi_line_bridge

Interface
REQ-001 Parameter LINE_WORDS, default 8, words per cache line; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter AXI_ID, default 4'd0, value driven on arid, awid and wid.
REQ-003 aclk  in  1  clock; all state changes on the rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  bridge idle and able to accept a request.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_uncached  in  1  1 = single-beat access, 0 = full-line burst.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wstrb  in  4  byte strobe; used for uncached writes only.
REQ-011 req_wline  in  32*LINE_WORDS  write data, word i at bits [32i+31:32i].
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rline  out  32*LINE_WORDS  read data, same word layout as req_wline; uncached read data in word 0.
REQ-014 resp_err  out  1  qualified by resp_valid; any non-OKAY rresp/bresp in the transaction.
REQ-015 AXI3 master ports ar*, r*, aw*, w*, b*: standard names and widths (ID 4, addr/data 32, len 8, lock 2).

Function
REQ-016 States: IDLE, AR, R, AW, W, B, DONE; req_ready=1 only in IDLE.
REQ-017 A request is accepted when req_valid && req_ready; addr, write, uncached, wstrb and wline are registered at acceptance and stay stable until DONE.
REQ-018 IDLE -> AR on an accepted read; IDLE -> AW on an accepted write.
REQ-019 Cached address = req_addr with the low log2(LINE_WORDS)+2 bits cleared; uncached address = req_addr with bits [1:0] cleared.
REQ-020 arlen/awlen = LINE_WORDS-1 when cached, 0 when uncached.
REQ-021 Fixed fields: arsize=awsize=3'b010; burst=INCR (2'b01); lock, cache, prot = 0.
REQ-022 arvalid=1 only in AR; on arvalid&&arready, AR -> R.
REQ-023 rready=1 only in R; each rvalid&&rready beat stores rdata in word[count], then increments count.
REQ-024 On the beat with rlast=1, R -> DONE, regardless of count.
REQ-025 A beat arriving after count already equals the burst length is discarded.
REQ-026 awvalid=1 only in AW; on awvalid&&awready, AW -> W.
REQ-027 In W: wvalid=1 and wdata=word[count].
REQ-028 In W: wstrb = 4'hF when cached, registered wstrb when uncached.
REQ-029 In W: wlast=1 when count = burst length-1.
REQ-030 On wvalid&&wready, count increments; on the last beat, W -> B.
REQ-031 bready=1 only in B; on bvalid, B -> DONE.
REQ-032 DONE lasts exactly one cycle: resp_valid=1, then -> IDLE.
REQ-033 count width is log2(LINE_WORDS)+1; count clears on entry to AR or AW.
REQ-034 resp_err is a sticky OR of (rresp!=0) over accepted read beats, or of (bresp!=0) for a write; it clears at acceptance.
REQ-035 Every valid output, once asserted, holds with its payload stable until the matching ready.
REQ-036 Responses with rid or bid other than AXI_ID are not filtered; a single outstanding transaction is guaranteed by construction.
REQ-037 Minimum latency, all readies high: cached read = 1 (AR) + LINE_WORDS (R) + 1 (DONE) cycles after acceptance.

Reset
REQ-038 Reset drives state=IDLE and count=0.
REQ-039 Reset clears all valid, ready, last and resp outputs to 0, except req_ready=1.
REQ-040 Reset clears resp_err and resp_rline to 0.
REQ-041 Reset asserted mid-transaction abandons the transaction with no resp_valid; the following cycle is IDLE.

Structure
REQ-042 Package axi_pkg holds the state enum, the BURST_INCR/FIXED/WRAP constants, SIZE_4B and RESP_OKAY; it is shared with other AXI users.
REQ-043 No sub-module; one FSM, one beat counter and the line registers.

Verification
REQ-044 Cached read, LINE_WORDS=8, addr 0x1000_0014, readies high, rdata=beat index -> araddr=0x1000_0000, arlen=7, arsize=2, resp_rline words 0..7 = 0..7, resp_valid at cycle 10, resp_err=0.
REQ-045 Cached write, LINE_WORDS=4, random awready/wready stalls -> awlen=3, wdata matches the registered line in order, wlast only on beat 3, resp_valid one cycle after bvalid.
REQ-046 Uncached write, addr 0x1FAF_F003, wstrb 4'b0010 -> awaddr=0x1FAF_F000, awlen=0, a single beat with wlast=1 and wstrb=4'b0010.
REQ-047 Read with rresp=2'b10 on beat 5 -> resp_err=1 with resp_valid; next clean request -> resp_err=0.
REQ-048 aresetn low during beat 3 of R -> all AXI valids low the next cycle, req_ready=1, no resp_valid; a new request completes normally.
REQ-049 req_valid held high, req_addr changing during a transaction -> only the value present at acceptance is used; req_ready stays low until after DONE.
